// File: rtl/rf_pkg.sv
// Shared register-file constants and the write-port arbiter state encoding.
package rf_pkg;

  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 32;

  typedef enum logic {
    RF_ARB_RUN   = 1'b0,
    RF_ARB_CLEAR = 1'b1
  } rf_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from last+1 and grants the first valid input.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  int   idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: round-robin write-back sharing plus a
// clear sweep that zeroes every register through the same registered port.
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [AW-1:0]     rf_addr,
  output logic [DW-1:0]     rf_din,
  output logic              rf_wr
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(RF_DEPTH);

  rf_arb_state_e state_reg, state_next;
  logic [IW-1:0] last_reg;
  logic [CW-1:0] cnt_reg;
  logic [AW-1:0] rf_addr_reg;
  logic [DW-1:0] rf_din_reg;
  logic          rf_wr_reg;

  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    grant_idx;
  logic             grant_ok;
  logic             handshake;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
    .valid     (req_valid),
    .last      (last_reg),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // A clear request wins over any pending write in the same cycle.
  assign grant_ok  = (state_reg == RF_ARB_RUN) && !clr_req && !rst;
  assign req_ready = grant_ok ? grant : '0;
  assign handshake = |req_ready;
  assign sel_addr  = req_addr[int'(grant_idx)*AW +: AW];
  assign sel_data  = req_data[int'(grant_idx)*DW +: DW];
  assign clr_busy  = (state_reg == RF_ARB_CLEAR);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RF_ARB_RUN:   if (clr_req) state_next = RF_ARB_CLEAR;
      RF_ARB_CLEAR: if (cnt_reg == CW'(RF_DEPTH - 1)) state_next = RF_ARB_RUN;
      default:      state_next = RF_ARB_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= RF_ARB_RUN;
      last_reg    <= IW'(N_REQ - 1);
      cnt_reg     <= '0;
      rf_wr_reg   <= 1'b0;
      rf_addr_reg <= '0;
      rf_din_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == RF_ARB_CLEAR) begin
        cnt_reg     <= cnt_reg + 1'b1;
        rf_wr_reg   <= 1'b1;
        rf_addr_reg <= AW'(cnt_reg);
        rf_din_reg  <= '0;
      end else begin
        cnt_reg   <= '0;
        rf_wr_reg <= 1'b0;
        if (handshake) begin
          last_reg <= grant_idx;
          // Register 0 is hard zero: the request is accepted but never written.
          if (sel_addr != '0) begin
            rf_wr_reg   <= 1'b1;
            rf_addr_reg <= sel_addr;
            rf_din_reg  <= sel_data;
          end
        end
      end
    end
  end

  assign rf_addr = rf_addr_reg;
  assign rf_din  = rf_din_reg;
  assign rf_wr   = rf_wr_reg;

endmodule
